// File: rtl/dm_sba.sv
// dm_sba: system-bus-access engine for the RISC-V debug module.
// Turns sbaddress/sbdata DMI accesses into single-beat bus transactions.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   dmactive_i             low clears all state synchronously
//   sbaddress_*/sbdata_*   DMI register writes/reads and their values
//   sbreadonaddr_i, sbreadondata_i, sbautoincrement_i, sbaccess_i  sbcs control
//   sberror_clr_i, sbbusyerror_clr_i  error clear strobes
//   sbaddress_o, sbdata_o, sbdata_valid_o, sbbusy_o, sberror_o, sbbusyerror_o  status
//   req_o, we_o, addr_o, wdata_o, be_o  bus request side
//   gnt_i, rvalid_i, rdata_i, err_i     bus response side
module dm_sba #(
  parameter int BusWidth      = 64,
  parameter int TimeoutCycles = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_we_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_we_i,
  input  logic                  sbdata_re_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbreadondata_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic [2:0]            sberror_clr_i,
  input  logic                  sbbusyerror_clr_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic [2:0]            sberror_o,
  output logic                  sbbusyerror_o,
  output logic                  req_o,
  output logic                  we_o,
  output logic [BusWidth-1:0]   addr_o,
  output logic [BusWidth-1:0]   wdata_o,
  output logic [BusWidth/8-1:0] be_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [BusWidth-1:0]   rdata_i,
  input  logic                  err_i
);
  localparam int ByteW = BusWidth / 8;
  localparam int OffW  = $clog2(ByteW);
  localparam int CntW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [2:0]      MaxSize = 3'(OffW);
  localparam logic [CntW-1:0] CntMax  = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [2:0] {Idle, Read, Write, WaitRead, WaitWrite} state_e;

  state_e              state_q;
  logic [BusWidth-1:0] addr_q, data_q, rdata_q, wbus_q;
  logic [ByteW-1:0]    be_q;
  logic [2:0]          size_q, err_q;
  logic [OffW-1:0]     off_q;
  logic                req_q, we_q, valid_q, busyerr_q;
  logic [CntW-1:0]     cnt_q;

  // Byte enables: 2^size contiguous lanes starting at the byte offset.
  function automatic logic [ByteW-1:0] lane_be(input logic [2:0] size, input logic [OffW-1:0] off);
    logic [ByteW-1:0] ones;
    ones = ByteW'((1 << (1 << size)) - 1);
    return ones << off;
  endfunction

  // Replicate the low 2^size bytes of the data register across the bus.
  function automatic logic [BusWidth-1:0] lane_wdata(input logic [BusWidth-1:0] d, input logic [2:0] size);
    logic [BusWidth-1:0] r;
    r = '0;
    for (int i = 0; i < ByteW; i++) r[8*i +: 8] = d[8*(i % (1 << size)) +: 8];
    return r;
  endfunction

  // Move the addressed lanes down to bit 0 and zero everything above the access size.
  function automatic logic [BusWidth-1:0] lane_rdata(input logic [BusWidth-1:0] d, input logic [2:0] size,
                                                     input logic [OffW-1:0] off);
    logic [BusWidth-1:0] m;
    m = '0;
    for (int i = 0; i < ByteW; i++) if (i < (1 << size)) m[8*i +: 8] = 8'hFF;
    return (d >> {off, 3'b000}) & m;
  endfunction

  logic                dmi_evt, trig, blocked, size_ok, aligned, start;
  logic                granted, responded, timeout, busy_evt;
  logic [OffW-1:0]     start_off, align_mask;
  logic [BusWidth-1:0] start_data;
  logic [2:0]          err_set;

  always_comb begin
    dmi_evt    = sbaddress_we_i | sbdata_we_i | sbdata_re_i;
    trig       = sbdata_we_i | (sbaddress_we_i & sbreadonaddr_i) | (sbdata_re_i & sbreadondata_i);
    blocked    = (err_q != 3'd0) | busyerr_q;
    // A same-cycle address write is already the address of the new access.
    start_off  = sbaddress_we_i ? sbaddress_i[OffW-1:0] : addr_q[OffW-1:0];
    start_data = sbdata_we_i ? sbdata_i : data_q;
    size_ok    = (sbaccess_i <= MaxSize);
    align_mask = ~({OffW{1'b1}} << sbaccess_i);
    aligned    = ~|(start_off & align_mask);
    granted    = ((state_q == Read) | (state_q == Write)) & gnt_i;
    responded  = ((state_q == WaitRead) | (state_q == WaitWrite)) & rvalid_i;
    // A handshake in the last allowed cycle still counts as in time.
    timeout    = (TimeoutCycles > 0) && (state_q != Idle) && !granted && !responded && (cnt_q == CntMax);
    busy_evt   = (state_q != Idle) & dmi_evt;
    start      = 1'b0;
    err_set    = 3'd0;
    if (state_q == Idle) begin
      if (trig && !blocked) begin
        if (!size_ok)      err_set = 3'd4;
        else if (!aligned) err_set = 3'd3;
        else               start   = 1'b1;
      end
    end else if (responded && err_i) begin
      err_set = 3'd2;
    end else if (timeout) begin
      err_set = 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle; addr_q <= '0; data_q <= '0; rdata_q <= '0; wbus_q <= '0;
      be_q <= '0; size_q <= '0; off_q <= '0; err_q <= '0; req_q <= 1'b0;
      we_q <= 1'b0; valid_q <= 1'b0; busyerr_q <= 1'b0; cnt_q <= '0;
    end else if (!dmactive_i) begin
      state_q <= Idle; addr_q <= '0; data_q <= '0; rdata_q <= '0; wbus_q <= '0;
      be_q <= '0; size_q <= '0; off_q <= '0; err_q <= '0; req_q <= 1'b0;
      we_q <= 1'b0; valid_q <= 1'b0; busyerr_q <= 1'b0; cnt_q <= '0;
    end else begin
      valid_q   <= 1'b0;
      err_q     <= (err_set != 3'd0) ? err_set : (err_q & ~sberror_clr_i);
      busyerr_q <= busy_evt | (busyerr_q & ~sbbusyerror_clr_i);
      case (state_q)
        Idle: begin
          cnt_q <= '0;
          if (sbaddress_we_i) addr_q <= sbaddress_i;
          if (sbdata_we_i)    data_q <= sbdata_i;
          if (start) begin
            state_q <= sbdata_we_i ? Write : Read;
            req_q   <= 1'b1;
            we_q    <= sbdata_we_i;
            size_q  <= sbaccess_i;
            off_q   <= start_off;
            be_q    <= lane_be(sbaccess_i, start_off);
            wbus_q  <= lane_wdata(start_data, sbaccess_i);
          end
        end
        Read, Write: begin
          if (granted) begin
            state_q <= (state_q == Read) ? WaitRead : WaitWrite;
            req_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (timeout) begin
            state_q <= Idle;
            req_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        WaitRead, WaitWrite: begin
          if (responded) begin
            state_q <= Idle;
            if (!err_i) begin
              if (state_q == WaitRead) begin
                rdata_q <= lane_rdata(rdata_i, size_q, off_q);
                valid_q <= 1'b1;
              end
              if (sbautoincrement_i) addr_q <= addr_q + (BusWidth'(1) << size_q);
            end
          end else if (timeout) begin
            state_q <= Idle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign sbaddress_o    = addr_q;
  assign sbdata_o       = rdata_q;
  assign sbdata_valid_o = valid_q;
  assign sbbusy_o       = (state_q != Idle);
  assign sberror_o      = err_q;
  assign sbbusyerror_o  = busyerr_q;
  assign req_o          = req_q;
  assign we_o           = we_q;
  assign addr_o         = addr_q;
  assign wdata_o        = wbus_q;
  assign be_o           = be_q;

endmodule

// File: tb/tb_dm_sba.sv
// tb_dm_sba: directed scenarios followed by randomized DMI/bus traffic,
// checked every cycle against a transaction-level model of the SBA engine.
module tb_dm_sba;
  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dmactive_i = 1'b1;
  logic [63:0] sbaddress_i = '0;
  logic        sbaddress_we_i = 1'b0;
  logic [63:0] sbdata_i = '0;
  logic        sbdata_we_i = 1'b0;
  logic        sbdata_re_i = 1'b0;
  logic        sbreadonaddr_i = 1'b0;
  logic        sbreadondata_i = 1'b0;
  logic        sbautoincrement_i = 1'b0;
  logic [2:0]  sbaccess_i = '0;
  logic [2:0]  sberror_clr_i = '0;
  logic        sbbusyerror_clr_i = 1'b0;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic [63:0] rdata_i = '0;
  logic        err_i = 1'b0;

  logic [63:0] sbaddress_o, sbdata_o, addr_o, wdata_o;
  logic        sbdata_valid_o, sbbusy_o, sbbusyerror_o, req_o, we_o;
  logic [2:0]  sberror_o;
  logic [7:0]  be_o;

  int tests = 0;
  int fails = 0;

  dm_sba #(.BusWidth(64), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
    .sbaddress_i(sbaddress_i), .sbaddress_we_i(sbaddress_we_i),
    .sbdata_i(sbdata_i), .sbdata_we_i(sbdata_we_i), .sbdata_re_i(sbdata_re_i),
    .sbreadonaddr_i(sbreadonaddr_i), .sbreadondata_i(sbreadondata_i),
    .sbautoincrement_i(sbautoincrement_i), .sbaccess_i(sbaccess_i),
    .sberror_clr_i(sberror_clr_i), .sbbusyerror_clr_i(sbbusyerror_clr_i),
    .sbaddress_o(sbaddress_o), .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid_o),
    .sbbusy_o(sbbusy_o), .sberror_o(sberror_o), .sbbusyerror_o(sbbusyerror_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 no access, 1 requesting the bus, 2 waiting for the response.
  int          m_phase, m_age;
  logic        m_write, m_valid, m_berr;
  logic [2:0]  m_size, m_off, m_err;
  logic [63:0] m_addr, m_wdata, m_rdata, m_wbus;
  logic [7:0]  m_be;

  task automatic m_clear();
    m_phase = 0; m_age = 0; m_write = 0; m_valid = 0; m_berr = 0;
    m_size = 0; m_off = 0; m_err = 0; m_addr = 0; m_wdata = 0;
    m_rdata = 0; m_wbus = 0; m_be = 0;
  endtask

  task automatic m_step();
    logic [2:0] eset;
    logic       bset, trig;
    int         n;
    eset = 0; bset = 0; m_valid = 0;
    if (m_phase != 0) begin
      if (sbaddress_we_i || sbdata_we_i || sbdata_re_i) bset = 1;
      if (m_phase == 1 && gnt_i) begin
        m_phase = 2; m_age = 0;
      end else if (m_phase == 2 && rvalid_i) begin
        m_phase = 0;
        if (err_i) eset = 2;
        else begin
          if (!m_write) begin
            m_rdata = 0;
            for (int b = 0; b < (1 << m_size); b++) m_rdata[8*b +: 8] = rdata_i[8*(m_off + b) +: 8];
            m_valid = 1;
          end
          if (sbautoincrement_i) m_addr = m_addr + (64'd1 << m_size);
        end
      end else if (m_age + 1 >= TO) begin
        m_phase = 0; eset = 1;
      end else begin
        m_age++;
      end
    end else begin
      if (sbaddress_we_i) m_addr = sbaddress_i;
      if (sbdata_we_i)    m_wdata = sbdata_i;
      trig = sbdata_we_i || (sbaddress_we_i && sbreadonaddr_i) || (sbdata_re_i && sbreadondata_i);
      if (trig && m_err == 0 && !m_berr) begin
        n = 1 << sbaccess_i;
        if (sbaccess_i > 3 || n > 8) eset = 4;
        else if (m_addr % 64'(n) != 0) eset = 3;
        else begin
          m_phase = 1; m_age = 0; m_write = sbdata_we_i; m_size = sbaccess_i;
          m_off = 3'(m_addr % 8);
          m_be = 8'(((1 << n) - 1) << m_off);
          for (int b = 0; b < 8; b++) m_wbus[8*b +: 8] = m_wdata[8*(b % n) +: 8];
        end
      end
    end
    m_err  = (eset != 0) ? eset : (m_err & ~sberror_clr_i);
    m_berr = bset ? 1'b1 : (m_berr & !sbbusyerror_clr_i);
  endtask

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || !dmactive_i) m_clear();
    else m_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk_i) begin
    #1;
    chk("sbaddress_o", sbaddress_o, m_addr);
    chk("addr_o", addr_o, m_addr);
    chk("sbdata_o", sbdata_o, m_rdata);
    chk("sbdata_valid_o", 64'(sbdata_valid_o), 64'(m_valid));
    chk("sbbusy_o", 64'(sbbusy_o), 64'(m_phase != 0));
    chk("sberror_o", 64'(sberror_o), 64'(m_err));
    chk("sbbusyerror_o", 64'(sbbusyerror_o), 64'(m_berr));
    chk("req_o", 64'(req_o), 64'(m_phase == 1));
    if (m_phase == 1) begin
      chk("we_o", 64'(we_o), 64'(m_write));
      chk("be_o", 64'(be_o), 64'(m_be));
      chk("wdata_o", wdata_o, m_wbus);
    end
  end

  task automatic after_edge();
    @(posedge clk_i); #1;
  endtask

  task automatic drive_random(input logic slow);
    logic [63:0] a;
    sbaddress_we_i    = ($urandom_range(0, 5) == 0);
    sbdata_we_i       = ($urandom_range(0, 6) == 0);
    sbdata_re_i       = ($urandom_range(0, 5) == 0);
    a = {$urandom(), $urandom() & 32'hFFFF_FFF8};
    if ($urandom_range(0, 1) == 0) a[2:0] = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 15) == 0) a = 64'hFFFF_FFFF_FFFF_FFF8;
    sbaddress_i       = a;
    sbdata_i          = {$urandom(), $urandom()};
    sbreadonaddr_i    = 1'($urandom_range(0, 1));
    sbreadondata_i    = 1'($urandom_range(0, 1));
    sbautoincrement_i = 1'($urandom_range(0, 1));
    sbaccess_i        = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
    sberror_clr_i     = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'b000;
    sbbusyerror_clr_i = ($urandom_range(0, 3) == 0);
    dmactive_i        = ($urandom_range(0, 99) != 0);
    gnt_i             = req_o && (slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0));
    rvalid_i          = slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 0);
    err_i             = ($urandom_range(0, 5) == 0);
    rdata_i           = {$urandom(), $urandom()};
  endtask

  initial begin
    // Reset state
    repeat (2) after_edge();
    chk("reset sbbusy", 64'(sbbusy_o), 64'd0);
    chk("reset req", 64'(req_o), 64'd0);
    chk("reset sbaddress", sbaddress_o, 64'd0);
    @(negedge clk_i); rst_ni = 1'b1;

    // 32-bit read on address write, upper lanes
    @(negedge clk_i);
    sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1; sbaddress_i = 64'h1004; sbaddress_we_i = 1'b1;
    after_edge();
    chk("rd req", 64'(req_o), 64'd1);
    chk("rd be", 64'(be_o), 64'hF0);
    chk("rd we", 64'(we_o), 64'd0);
    @(negedge clk_i); sbaddress_we_i = 1'b0; gnt_i = 1'b1;
    @(negedge clk_i); gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 64'hDEADBEEF_00000000;
    after_edge();
    chk("rd sbdata", sbdata_o, 64'hDEADBEEF);
    chk("rd valid", 64'(sbdata_valid_o), 64'd1);
    chk("rd busy", 64'(sbbusy_o), 64'd0);
    @(negedge clk_i); rvalid_i = 1'b0;

    // Byte write with autoincrement
    sbreadonaddr_i = 1'b0; sbaddress_i = 64'h3; sbaddress_we_i = 1'b1;
    @(negedge clk_i); sbaddress_we_i = 1'b0;
    sbaccess_i = 3'd0; sbautoincrement_i = 1'b1; sbdata_i = 64'hAB; sbdata_we_i = 1'b1;
    after_edge();
    chk("wr be", 64'(be_o), 64'h08);
    chk("wr byte3", 64'(wdata_o[31:24]), 64'hAB);
    chk("wr we", 64'(we_o), 64'd1);
    @(negedge clk_i); sbdata_we_i = 1'b0; gnt_i = 1'b1;
    @(negedge clk_i); gnt_i = 1'b0; rvalid_i = 1'b1; err_i = 1'b0;
    after_edge();
    chk("autoinc addr", sbaddress_o, 64'h4);
    @(negedge clk_i); rvalid_i = 1'b0; sbautoincrement_i = 1'b0;

    // Unaligned word access, blocked start, then clear
    sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1; sbaddress_i = 64'h2; sbaddress_we_i = 1'b1;
    after_edge();
    chk("unaligned err", 64'(sberror_o), 64'd3);
    chk("unaligned req", 64'(req_o), 64'd0);
    @(negedge clk_i); sbaddress_we_i = 1'b0; sbaccess_i = 3'd0; sbreadondata_i = 1'b1; sbdata_re_i = 1'b1;
    after_edge();
    chk("blocked req", 64'(req_o), 64'd0);
    @(negedge clk_i); sbdata_re_i = 1'b0; sberror_clr_i = 3'b111;
    after_edge();
    chk("cleared err", 64'(sberror_o), 64'd0);
    @(negedge clk_i); sberror_clr_i = 3'b000; sbdata_re_i = 1'b1;
    after_edge();
    chk("restart req", 64'(req_o), 64'd1);
    @(negedge clk_i); sbdata_re_i = 1'b0; gnt_i = 1'b1;
    @(negedge clk_i); gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 64'h0000_0000_00AA_0000;
    after_edge();
    chk("byte2 read", sbdata_o, 64'hAA);
    @(negedge clk_i); rvalid_i = 1'b0;

    // DMI write while waiting for a write response
    sbreadonaddr_i = 1'b0; sbreadondata_i = 1'b0; sbaddress_i = 64'h10; sbaddress_we_i = 1'b1;
    @(negedge clk_i); sbaddress_we_i = 1'b0; sbaccess_i = 3'd3;
    sbdata_i = 64'h1122334455667788; sbdata_we_i = 1'b1;
    @(negedge clk_i); sbdata_we_i = 1'b0; gnt_i = 1'b1;
    @(negedge clk_i); gnt_i = 1'b0; sbdata_i = 64'hFFFF_FFFF_FFFF_FFFF; sbdata_we_i = 1'b1;
    after_edge();
    chk("busyerr set", 64'(sbbusyerror_o), 64'd1);
    chk("busyerr busy", 64'(sbbusy_o), 64'd1);
    @(negedge clk_i); sbdata_we_i = 1'b0; rvalid_i = 1'b1;
    after_edge();
    chk("busyerr sticky", 64'(sbbusyerror_o), 64'd1);
    chk("busyerr sbdata", sbdata_o, 64'hAA);
    @(negedge clk_i); rvalid_i = 1'b0; sbbusyerror_clr_i = 1'b1;
    after_edge();
    chk("busyerr clear", 64'(sbbusyerror_o), 64'd0);
    @(negedge clk_i); sbbusyerror_clr_i = 1'b0;

    // Grant timeout
    sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1; sbaddress_i = 64'h20; sbaddress_we_i = 1'b1;
    after_edge();
    chk("to req0", 64'(req_o), 64'd1);
    @(negedge clk_i); sbaddress_we_i = 1'b0;
    for (int i = 1; i < TO; i++) begin
      after_edge();
      chk("to req held", 64'(req_o), 64'd1);
    end
    after_edge();
    chk("to req drop", 64'(req_o), 64'd0);
    chk("to sberror", 64'(sberror_o), 64'd1);
    chk("to busy", 64'(sbbusy_o), 64'd0);
    @(negedge clk_i); rvalid_i = 1'b1; rdata_i = 64'h1234;
    after_edge();
    chk("stray rvalid", 64'(sbdata_valid_o), 64'd0);
    @(negedge clk_i); rvalid_i = 1'b0; sberror_clr_i = 3'b111;
    @(negedge clk_i); sberror_clr_i = 3'b000;

    // dmactive drop while waiting for read data
    sbaccess_i = 3'd3; sbaddress_i = 64'h40; sbaddress_we_i = 1'b1;
    @(negedge clk_i); sbaddress_we_i = 1'b0; gnt_i = 1'b1;
    @(negedge clk_i); gnt_i = 1'b0; dmactive_i = 1'b0;
    after_edge();
    chk("dmact addr", sbaddress_o, 64'd0);
    chk("dmact sbdata", sbdata_o, 64'd0);
    chk("dmact busy", 64'(sbbusy_o), 64'd0);
    @(negedge clk_i); dmactive_i = 1'b1; rvalid_i = 1'b1; rdata_i = 64'h5555;
    after_edge();
    chk("dmact valid", 64'(sbdata_valid_o), 64'd0);
    chk("dmact sbdata2", sbdata_o, 64'd0);
    @(negedge clk_i); rvalid_i = 1'b0;

    // Asynchronous reset in the middle of a write request
    sbreadonaddr_i = 1'b0; sbaddress_i = 64'h8; sbaddress_we_i = 1'b1;
    @(negedge clk_i); sbaddress_we_i = 1'b0; sbdata_i = 64'hCAFE; sbdata_we_i = 1'b1;
    after_edge();
    chk("pre-rst req", 64'(req_o), 64'd1);
    @(negedge clk_i); sbdata_we_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst req", 64'(req_o), 64'd0);
    chk("arst we", 64'(we_o), 64'd0);
    chk("arst be", 64'(be_o), 64'd0);
    chk("arst wdata", wdata_o, 64'd0);
    chk("arst addr", sbaddress_o, 64'd0);
    chk("arst busy", 64'(sbbusy_o), 64'd0);
    @(negedge clk_i); rst_ni = 1'b1;

    // Randomized traffic, alternating fast and stalling bus behaviour
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_i);
      drive_random(((c / 200) % 3) == 2);
    end
    @(negedge clk_i);
    dmactive_i = 1'b1; sbaddress_we_i = 1'b0; sbdata_we_i = 1'b0; sbdata_re_i = 1'b0;
    gnt_i = 1'b0; rvalid_i = 1'b0;
    repeat (2) after_edge();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
